// File: rtl/riscv_lsu.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | riscv_lsu : single-outstanding byte/half/word load-store unit (req/gnt/rvalid)
// | Optional RISCV_LSU_MISALIGN_CHK_EN: traps misaligned half/word accesses     |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module riscv_lsu #(
  parameter int ADDR_W      = 32,
  parameter int RSP_TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              lsu_valid_i,
  output logic              lsu_ready_o,
  input  logic              lsu_store_i,
  input  logic [1:0]        lsu_size_i,
  input  logic              lsu_zero_ext_i,
  input  logic [ADDR_W-1:0] lsu_addr_i,
  input  logic [31:0]       lsu_wdata_i,
  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [3:0]        mem_be_o,
  output logic [31:0]       mem_wdata_o,
  input  logic              mem_gnt_i,
  input  logic              mem_rvalid_i,
  input  logic [31:0]       mem_rdata_i,
  output logic              lsu_done_o,
  output logic [31:0]       lsu_rdata_o,
  output logic              lsu_err_o
);

  localparam int CNT_W = (RSP_TIMEOUT > 2) ? $clog2(RSP_TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(RSP_TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t            state, state_nxt;
  logic              store_q, zext_q, err_q;
  logic [1:0]        size_q, off_q;
  logic [ADDR_W-1:0] addr_q;
  logic [3:0]        be_q, be_in;
  logic [31:0]       wdata_q, wdata_in, rdata_q, fmt_rdata, fin_rdata, sh_b, sh_h;
  logic [CNT_W-1:0]  cnt_q;
  logic              accept, misalign, bad_req, finish, fin_err, cnt_clr, cnt_inc;

  assign accept = lsu_valid_i && (state == IDLE);

`ifdef RISCV_LSU_MISALIGN_CHK_EN
  assign misalign = ((lsu_size_i == 2'b01) && lsu_addr_i[0]) ||
                    ((lsu_size_i == 2'b10) && (lsu_addr_i[1:0] != 2'b00));
`else
  assign misalign = 1'b0;
`endif

  assign bad_req = (lsu_size_i == 2'b11) || misalign;

  always_comb begin
    be_in    = 4'b0000;
    wdata_in = lsu_wdata_i;
    case (lsu_size_i)
      2'b00: begin
        be_in    = 4'b0001 << lsu_addr_i[1:0];
        wdata_in = {4{lsu_wdata_i[7:0]}};
      end
      2'b01: begin
        be_in    = 4'b0011 << {lsu_addr_i[1], 1'b0};
        wdata_in = {2{lsu_wdata_i[15:0]}};
      end
      2'b10:   be_in = 4'b1111;
      default: be_in = 4'b0000;
    endcase
  end

  // Lane select for the returning word, using the offset captured at accept.
  assign sh_b = mem_rdata_i >> {off_q, 3'b000};
  assign sh_h = mem_rdata_i >> {off_q[1], 4'b0000};

  always_comb begin
    case (size_q)
      2'b00:   fmt_rdata = {{24{~zext_q & sh_b[7]}}, sh_b[7:0]};
      2'b01:   fmt_rdata = {{16{~zext_q & sh_h[15]}}, sh_h[15:0]};
      default: fmt_rdata = mem_rdata_i;
    endcase
  end

  always_comb begin
    state_nxt = state;
    finish    = 1'b0;
    fin_err   = 1'b0;
    fin_rdata = 32'h0;
    cnt_clr   = 1'b0;
    cnt_inc   = 1'b0;
    case (state)
      IDLE: begin
        if (lsu_valid_i) begin
          if (bad_req) begin
            state_nxt = DONE;
            finish    = 1'b1;
            fin_err   = 1'b1;
          end else begin
            state_nxt = REQ;
          end
        end
      end
      REQ: begin
        if (mem_gnt_i) begin
          if (store_q) begin
            state_nxt = DONE;
            finish    = 1'b1;
          end else begin
            state_nxt = WAIT;
            cnt_clr   = 1'b1;
          end
        end
      end
      WAIT: begin
        if (mem_rvalid_i) begin
          state_nxt = DONE;
          finish    = 1'b1;
          fin_rdata = fmt_rdata;
        end else if ((RSP_TIMEOUT != 0) && (cnt_q == CNT_LAST)) begin
          state_nxt = DONE;
          finish    = 1'b1;
          fin_err   = 1'b1;
        end else begin
          cnt_inc = 1'b1;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= IDLE;
      store_q <= 1'b0;
      zext_q  <= 1'b0;
      size_q  <= 2'b00;
      off_q   <= 2'b00;
      addr_q  <= '0;
      be_q    <= 4'b0000;
      wdata_q <= 32'h0;
      rdata_q <= 32'h0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        store_q <= lsu_store_i;
        zext_q  <= lsu_zero_ext_i;
        size_q  <= lsu_size_i;
        off_q   <= lsu_addr_i[1:0];
        addr_q  <= {lsu_addr_i[ADDR_W-1:2], 2'b00};
        be_q    <= be_in;
        wdata_q <= wdata_in;
      end
      if (cnt_clr) begin
        cnt_q <= '0;
      end else if (cnt_inc) begin
        cnt_q <= cnt_q + 1'b1;
      end
      if (finish) begin
        rdata_q <= fin_rdata;
        err_q   <= fin_err;
      end
    end
  end

  assign lsu_ready_o = (state == IDLE);
  assign mem_req_o   = (state == REQ);
  assign mem_we_o    = store_q;
  assign mem_addr_o  = addr_q;
  assign mem_be_o    = be_q;
  assign mem_wdata_o = wdata_q;
  assign lsu_done_o  = (state == DONE);
  assign lsu_rdata_o = rdata_q;
  assign lsu_err_o   = err_q;

endmodule
`default_nettype wire

// File: tb/tb_riscv_lsu.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_riscv_lsu : directed vector bench for riscv_lsu (RSP_TIMEOUT = 4)       |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module tb_riscv_lsu;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        lsu_valid_i = 1'b0, lsu_store_i = 1'b0, lsu_zero_ext_i = 1'b0;
  logic [1:0]  lsu_size_i = 2'b00;
  logic [31:0] lsu_addr_i = 32'h0, lsu_wdata_i = 32'h0;
  logic        mem_gnt_i = 1'b0, mem_rvalid_i = 1'b0;
  logic [31:0] mem_rdata_i = 32'h0;
  logic        lsu_ready_o, mem_req_o, mem_we_o, lsu_done_o, lsu_err_o;
  logic [31:0] mem_addr_o, mem_wdata_o, lsu_rdata_o;
  logic [3:0]  mem_be_o;

  int errors = 0;
  int checks = 0;

  riscv_lsu #(.ADDR_W(32), .RSP_TIMEOUT(4)) dut (
    .clk(clk), .reset_n(reset_n),
    .lsu_valid_i(lsu_valid_i), .lsu_ready_o(lsu_ready_o),
    .lsu_store_i(lsu_store_i), .lsu_size_i(lsu_size_i),
    .lsu_zero_ext_i(lsu_zero_ext_i), .lsu_addr_i(lsu_addr_i),
    .lsu_wdata_i(lsu_wdata_i),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
    .mem_be_o(mem_be_o), .mem_wdata_o(mem_wdata_o),
    .mem_gnt_i(mem_gnt_i), .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i),
    .lsu_done_o(lsu_done_o), .lsu_rdata_o(lsu_rdata_o), .lsu_err_o(lsu_err_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        store;
    logic [1:0]  size;
    logic        zext;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          gnt_dly;
    logic [31:0] rdata;
    logic        access;
    logic [31:0] e_addr;
    logic [3:0]  e_be;
    logic [31:0] e_wdata;
    logic [31:0] e_rdata;
    logic        e_err;
  } vec_t;

  vec_t vecs [0:9];

  function automatic vec_t mk(logic st, logic [1:0] sz, logic zx, logic [31:0] ad,
                              logic [31:0] wd, int dly, logic [31:0] rd, logic acc,
                              logic [31:0] ea, logic [3:0] eb, logic [31:0] ew,
                              logic [31:0] er, logic ee);
    vec_t v;
    v.store = st; v.size = sz; v.zext = zx; v.addr = ad; v.wdata = wd;
    v.gnt_dly = dly; v.rdata = rd; v.access = acc; v.e_addr = ea; v.e_be = eb;
    v.e_wdata = ew; v.e_rdata = er; v.e_err = ee;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic issue(input logic st, input logic [1:0] sz, input logic zx,
                       input logic [31:0] ad, input logic [31:0] wd);
    lsu_valid_i = 1'b1; lsu_store_i = st; lsu_size_i = sz;
    lsu_zero_ext_i = zx; lsu_addr_i = ad; lsu_wdata_i = wd;
  endtask

  task automatic run_vec(input int i);
    vec_t v;
    v = vecs[i];
    @(negedge clk);
    chk($sformatf("v%0d ready", i), {31'b0, lsu_ready_o}, 32'd1);
    issue(v.store, v.size, v.zext, v.addr, v.wdata);
    @(negedge clk);
    lsu_valid_i = 1'b0;
    if (!v.access) begin
      chk($sformatf("v%0d noreq", i), {31'b0, mem_req_o}, 32'd0);
      chk($sformatf("v%0d done", i), {31'b0, lsu_done_o}, 32'd1);
    end else begin
      for (int k = 0; k <= v.gnt_dly; k++) begin
        chk($sformatf("v%0d req c%0d", i, k), {31'b0, mem_req_o}, 32'd1);
        chk($sformatf("v%0d addr c%0d", i, k), mem_addr_o, v.e_addr);
        chk($sformatf("v%0d be c%0d", i, k), {28'b0, mem_be_o}, {28'b0, v.e_be});
        chk($sformatf("v%0d we c%0d", i, k), {31'b0, mem_we_o}, {31'b0, v.store});
        if (v.store) chk($sformatf("v%0d wdata c%0d", i, k), mem_wdata_o, v.e_wdata);
        chk($sformatf("v%0d early done c%0d", i, k), {31'b0, lsu_done_o}, 32'd0);
        mem_gnt_i = (k == v.gnt_dly);
        @(negedge clk);
      end
      mem_gnt_i = 1'b0;
      if (!v.store) begin
        chk($sformatf("v%0d wait noreq", i), {31'b0, mem_req_o}, 32'd0);
        chk($sformatf("v%0d wait nodone", i), {31'b0, lsu_done_o}, 32'd0);
        mem_rvalid_i = 1'b1;
        mem_rdata_i  = v.rdata;
        @(negedge clk);
        mem_rvalid_i = 1'b0;
        mem_rdata_i  = 32'h0;
      end
      chk($sformatf("v%0d done", i), {31'b0, lsu_done_o}, 32'd1);
    end
    chk($sformatf("v%0d err", i), {31'b0, lsu_err_o}, {31'b0, v.e_err});
    chk($sformatf("v%0d rdata", i), lsu_rdata_o, v.e_rdata);
    @(negedge clk);
    chk($sformatf("v%0d done pulse", i), {31'b0, lsu_done_o}, 32'd0);
    chk($sformatf("v%0d idle", i), {31'b0, lsu_ready_o}, 32'd1);
    chk($sformatf("v%0d rdata hold", i), lsu_rdata_o, v.e_rdata);
  endtask

  initial begin
    //          st    sz     zx    addr          wdata         dly rdata         acc   e_addr        e_be     e_wdata       e_rdata       e_err
    vecs[0] = mk(1'b0, 2'b10, 1'b0, 32'h0000_0100, 32'h0,        0, 32'hDEAD_BEEF, 1'b1, 32'h0000_0100, 4'b1111, 32'h0,        32'hDEAD_BEEF, 1'b0);
    vecs[1] = mk(1'b0, 2'b00, 1'b0, 32'h0000_0203, 32'h0,        0, 32'h80FF_1234, 1'b1, 32'h0000_0200, 4'b1000, 32'h0,        32'hFFFF_FF80, 1'b0);
    vecs[2] = mk(1'b0, 2'b00, 1'b1, 32'h0000_0203, 32'h0,        0, 32'h80FF_1234, 1'b1, 32'h0000_0200, 4'b1000, 32'h0,        32'h0000_0080, 1'b0);
    vecs[3] = mk(1'b1, 2'b01, 1'b0, 32'h0000_0042, 32'h0000_ABCD, 3, 32'h0,        1'b1, 32'h0000_0040, 4'b1100, 32'hABCD_ABCD, 32'h0,        1'b0);
    vecs[4] = mk(1'b1, 2'b00, 1'b0, 32'h0000_0011, 32'h1234_565A, 0, 32'h0,        1'b1, 32'h0000_0010, 4'b0010, 32'h5A5A_5A5A, 32'h0,        1'b0);
    vecs[5] = mk(1'b0, 2'b01, 1'b0, 32'h0000_0006, 32'h0,        1, 32'h8001_7FFE, 1'b1, 32'h0000_0004, 4'b1100, 32'h0,        32'hFFFF_8001, 1'b0);
    vecs[6] = mk(1'b0, 2'b01, 1'b1, 32'h0000_0004, 32'h0,        0, 32'h8001_F00D, 1'b1, 32'h0000_0004, 4'b0011, 32'h0,        32'h0000_F00D, 1'b0);
    vecs[7] = mk(1'b1, 2'b10, 1'b0, 32'h0000_0200, 32'hCAFE_F00D, 1, 32'h0,        1'b1, 32'h0000_0200, 4'b1111, 32'hCAFE_F00D, 32'h0,        1'b0);
    vecs[8] = mk(1'b0, 2'b11, 1'b0, 32'h0000_0300, 32'h0,        0, 32'h0,        1'b0, 32'h0,        4'b0000, 32'h0,        32'h0,        1'b1);
`ifdef RISCV_LSU_MISALIGN_CHK_EN
    vecs[9] = mk(1'b0, 2'b10, 1'b0, 32'h0000_0101, 32'h0,        0, 32'h1122_3344, 1'b0, 32'h0,        4'b0000, 32'h0,        32'h0,        1'b1);
`else
    vecs[9] = mk(1'b0, 2'b10, 1'b0, 32'h0000_0101, 32'h0,        0, 32'h1122_3344, 1'b1, 32'h0000_0100, 4'b1111, 32'h0,        32'h1122_3344, 1'b0);
`endif

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst ready", {31'b0, lsu_ready_o}, 32'd1);
    chk("rst req",   {31'b0, mem_req_o},   32'd0);
    chk("rst we",    {31'b0, mem_we_o},    32'd0);
    chk("rst addr",  mem_addr_o,           32'd0);
    chk("rst be",    {28'b0, mem_be_o},    32'd0);
    chk("rst wdata", mem_wdata_o,          32'd0);
    chk("rst done",  {31'b0, lsu_done_o},  32'd0);
    chk("rst rdata", lsu_rdata_o,          32'd0);
    chk("rst err",   {31'b0, lsu_err_o},   32'd0);
    reset_n = 1'b1;

    for (int i = 0; i < 10; i++) run_vec(i);

    // Response timeout: 4 WAIT cycles, then DONE with err; late rvalid ignored
    @(negedge clk);
    issue(1'b0, 2'b10, 1'b0, 32'h0000_0080, 32'h0);
    @(negedge clk);
    lsu_valid_i = 1'b0;
    mem_gnt_i   = 1'b1;
    @(negedge clk);
    mem_gnt_i = 1'b0;
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("to wait c%0d", k), {31'b0, lsu_done_o}, 32'd0);
      @(negedge clk);
    end
    chk("to done",  {31'b0, lsu_done_o}, 32'd1);
    chk("to err",   {31'b0, lsu_err_o},  32'd1);
    chk("to rdata", lsu_rdata_o,         32'd0);
    repeat (2) @(negedge clk);
    mem_rvalid_i = 1'b1;
    mem_rdata_i  = 32'h5555_AAAA;
    @(negedge clk);
    mem_rvalid_i = 1'b0;
    mem_rdata_i  = 32'h0;
    chk("late rv nodone", {31'b0, lsu_done_o},  32'd0);
    chk("late rv idle",   {31'b0, lsu_ready_o}, 32'd1);
    chk("late rv err",    {31'b0, lsu_err_o},   32'd1);
    chk("late rv rdata",  lsu_rdata_o,          32'd0);

    // Reset while in REQ: request drops without waiting for a clock edge
    issue(1'b0, 2'b10, 1'b0, 32'h0000_0300, 32'h0);
    @(negedge clk);
    lsu_valid_i = 1'b0;
    chk("rreq req", {31'b0, mem_req_o}, 32'd1);
    reset_n = 1'b0;
    #1;
    chk("rreq req drop", {31'b0, mem_req_o},   32'd0);
    chk("rreq ready",    {31'b0, lsu_ready_o}, 32'd1);
    @(negedge clk);
    reset_n = 1'b1;

    // Reset while in WAIT, then an rvalid after release must be ignored
    @(negedge clk);
    issue(1'b0, 2'b10, 1'b0, 32'h0000_0300, 32'h0);
    @(negedge clk);
    lsu_valid_i = 1'b0;
    mem_gnt_i   = 1'b1;
    @(negedge clk);
    mem_gnt_i = 1'b0;
    reset_n   = 1'b0;
    #1;
    chk("rwait ready", {31'b0, lsu_ready_o}, 32'd1);
    chk("rwait done",  {31'b0, lsu_done_o},  32'd0);
    chk("rwait err",   {31'b0, lsu_err_o},   32'd0);
    @(negedge clk);
    reset_n      = 1'b1;
    mem_rvalid_i = 1'b1;
    mem_rdata_i  = 32'h1234_5678;
    @(negedge clk);
    mem_rvalid_i = 1'b0;
    chk("rwait rv nodone", {31'b0, lsu_done_o},  32'd0);
    chk("rwait rv ready",  {31'b0, lsu_ready_o}, 32'd1);
    chk("rwait rv rdata",  lsu_rdata_o,          32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/riscv_lsu.md
Name: riscv_lsu

Overview:
- Load/store unit directly downstream of the RISC-V execute stage.
- Takes the ALU result as the effective address, plus store data and access size, and performs one byte/half/word access on a single-outstanding req/gnt/rvalid data-memory port.
- Returns sign- or zero-extended load data to writeback with a one-cycle done pulse.
- Accepts one transaction at a time.

Parameters:
ADDR_W, 32, width of effective and memory address.
RSP_TIMEOUT, 255, max cycles waited for mem_rvalid_i after grant; 0 disables timeout.

Ports:
clk  in  1  clock, all state on rising edge.
reset_n  in  1  reset, asynchronous, active-low.
lsu_valid_i  in  1  request valid from execute stage.
lsu_ready_o  out  1  request accepted when valid & ready.
lsu_store_i  in  1  1 = store, 0 = load.
lsu_size_i  in  2  00 byte, 01 half, 10 word, 11 reserved.
lsu_zero_ext_i  in  1  load zero-extends (LBU/LHU) when 1, sign-extends when 0.
lsu_addr_i  in  ADDR_W  effective address (ALU result).
lsu_wdata_i  in  32  store data, LSB-justified.
mem_req_o  out  1  memory request.
mem_we_o  out  1  write enable.
mem_addr_o  out  ADDR_W  word-aligned address, bits [1:0] = 0.
mem_be_o  out  4  byte enables.
mem_wdata_o  out  32  lane-replicated write data.
mem_gnt_i  in  1  request granted this cycle.
mem_rvalid_i  in  1  read data valid.
mem_rdata_i  in  32  read data.
lsu_done_o  out  1  one-cycle completion pulse.
lsu_rdata_o  out  32  formatted load data; 0 for stores and errors.
lsu_err_o  out  1  error flag, valid with lsu_done_o.

Behaviour:
- FSM states: IDLE, REQ, WAIT, DONE.
- lsu_ready_o = (state == IDLE).
- Reset values:
  - state = IDLE.
  - mem_req_o, mem_we_o, mem_addr_o, mem_be_o, mem_wdata_o = 0.
  - lsu_done_o, lsu_rdata_o, lsu_err_o = 0.
  - timeout counter = 0.
- Reset mid-operation: mem_req_o drops immediately; the transaction is abandoned. An rvalid arriving in IDLE is ignored.
- IDLE: on accept, register store, size, zero_ext, addr and wdata.
  - size = 11: go to DONE with err = 1; no memory access.
  - Otherwise go to REQ.
- REQ:
  - mem_req_o = 1; addr, we, be and wdata held stable until mem_gnt_i.
  - On gnt with store: go to DONE.
  - On gnt with load: go to WAIT and clear the counter.
- WAIT:
  - rvalid is sampled only in WAIT, never in the grant cycle.
  - On mem_rvalid_i: capture the formatted load data and go to DONE with err = 0.
  - Otherwise increment the counter. If RSP_TIMEOUT != 0 and counter == RSP_TIMEOUT - 1, go to DONE with err = 1 and rdata = 0.
  - A late rvalid arriving after a timeout is ignored.
- DONE: lsu_done_o = 1 for exactly one cycle, then IDLE. lsu_rdata_o and lsu_err_o hold their values until the next DONE.
- Byte enables, with a = addr[1:0]:
  - byte: 4'b0001 << a.
  - half: 4'b0011 << {a[1], 0}.
  - word: 4'b1111.
- Write data:
  - byte: {4{wdata[7:0]}}.
  - half: {2{wdata[15:0]}}.
  - word: wdata.
- Load formatting:
  - shifted = rdata >> (8*a) for byte; >> (16*a[1]) for half.
  - Extend bit 7 (byte) or bit 15 (half) unless zero_ext. Word passes through unchanged.
- Latency:
  - store with same-cycle gnt: accept T0, REQ T1, done T2.
  - load with gnt T1 and rvalid T2: done T3.
- Gnt stall: REQ persists indefinitely; no timeout applies in REQ.

Optional Feature:
RISCV_LSU_MISALIGN_CHK_EN
- Defined:
  - Misaligned means half with addr[0] = 1, or word with addr[1:0] != 0.
  - A misaligned accept goes IDLE -> DONE with err = 1, rdata = 0, and no mem_req_o.
- Undefined:
  - No misalignment check; lsu_err_o is never set for alignment.
  - Half uses a[1] only; word ignores a[1:0] (aligned down).

Test Plan:
- LW addr 0x100, gnt T1, rvalid T2, rdata 0xDEADBEEF -> mem_addr 0x100, be 1111; done T3, rdata 0xDEADBEEF, err 0.
- LB addr 0x203, rdata 0x80FF_1234; then LBU same address -> first rdata 0xFFFF_FF80, second 0x0000_0080; be 1000 both.
- SH addr 0x42, wdata 0x0000_ABCD, gnt delayed 3 cycles -> mem_req held 3 cycles with addr 0x40, be 1100, wdata 0xABCD_ABCD, we 1; done 1 cycle after gnt, err 0.
- RSP_TIMEOUT = 4, LW granted, no rvalid -> done 4 cycles after gnt with err 1, rdata 0; rvalid injected 2 cycles later is ignored and state stays IDLE.
- size = 11 request; separately, reset_n low during WAIT -> reserved size gives done next cycle with err 1 and no req; reset drops mem_req_o/done immediately, ready 1 after release.
- LW addr 0x101 -> with RISCV_LSU_MISALIGN_CHK_EN: no req, done T1 with err 1; without: access 0x100 with be 1111, err 0.
